// File: rtl/alu_pkg.sv
// Shared types for the ALU execute/write-back stage:
// op codes, FSM states and default widths.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_XOR,
    OP_SLT,
    OP_SHL,
    OP_MUL
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_EXEC,
    S_WB
  } state_e;

endpackage

// File: rtl/alu_exec_unit_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// The start cycle performs the first step; done flags the last.
module seq_multiplier
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int PW = 2 * DATA_W;
  localparam int CW = $clog2(DATA_W) + 1;

  logic [PW-1:0]     acc;
  logic [PW-1:0]     mcand;
  logic [DATA_W-1:0] mplier;
  logic [CW-1:0]     cnt;

  logic [PW-1:0]     src_acc;
  logic [PW-1:0]     src_a;
  logic [DATA_W-1:0] src_b;
  logic [PW-1:0]     sum;

  always_comb begin
    src_acc = busy ? acc : '0;
    src_a   = busy ? mcand : PW'(a);
    src_b   = busy ? mplier : b;
    sum     = src_acc + (src_b[0] ? src_a : '0);
  end

  // product is the combinational sum, valid in the done cycle
  assign done    = busy && (cnt == CW'(DATA_W - 1));
  assign product = sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (busy || start) begin
      acc    <= sum;
      mcand  <= src_a << 1;
      mplier <= src_b >> 1;
      cnt    <= busy ? cnt + CW'(1) : CW'(1);
      busy   <= !done;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute/write-back stage behind the register file.
// Define ALU_MUL_EN to execute op 111 as an iterative MUL.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int ADDR_W = alu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [ADDR_W-1:0] cmd_rs2,
  input  logic [ADDR_W-1:0] cmd_rd,
  output logic [ADDR_W-1:0] ra1,
  output logic [ADDR_W-1:0] ra2,
  input  logic [DATA_W-1:0] rd1,
  input  logic [DATA_W-1:0] rd2,
  output logic [ADDR_W-1:0] wa3,
  output logic              we3,
  output logic [DATA_W-1:0] wd3,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_zero,
  output logic              flag_carry,
  output logic              err
);

  state_e            state;
  state_e            state_nx;
  op_e               op_q;
  logic [ADDR_W-1:0] rs1_q;
  logic [ADDR_W-1:0] rs2_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              wb_we;

  logic              accept;
  logic [DATA_W:0]   wide;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              exec_fin;
  logic              exec_err;
  logic [DATA_W-1:0] res_nx;
  logic              carry_nx;

  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (accept) state_nx = S_READ;
      S_READ:  state_nx = S_LATCH;
      S_LATCH: state_nx = S_EXEC;
      S_EXEC:  if (exec_fin) state_nx = S_WB;
      S_WB:    state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    unique case (op_q)
      OP_ADD: begin
        wide    = {1'b0, a_q} + {1'b0, b_q};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      OP_SUB: begin
        wide    = {1'b0, a_q} - {1'b0, b_q};
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SLT: alu_res = DATA_W'($signed(a_q) < $signed(b_q));
      OP_SHL: begin
        // the last bit shifted out lands exactly on bit DATA_W
        wide    = {1'b0, a_q} << b_q[2:0];
        alu_res = wide[DATA_W-1:0];
        alu_c   = wide[DATA_W];
      end
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  logic                mul_start;
  logic                mul_busy;
  logic                mul_done;
  logic [2*DATA_W-1:0] mul_p;
  logic                is_mul;

  assign is_mul    = (op_q == OP_MUL);
  assign mul_start = (state == S_EXEC) && is_mul && !mul_busy;

  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a_q),
    .b       (b_q),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_p)
  );

  assign exec_fin = is_mul ? mul_done : 1'b1;
  assign exec_err = 1'b0;
  assign res_nx   = is_mul ? mul_p[DATA_W-1:0] : alu_res;
  assign carry_nx = is_mul ? |mul_p[2*DATA_W-1:DATA_W] : alu_c;
`else
  assign exec_fin = 1'b1;
  assign exec_err = (op_q == OP_MUL);
  assign res_nx   = alu_res;
  assign carry_nx = alu_c;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      op_q       <= OP_ADD;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      wb_we      <= 1'b0;
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      err        <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q  <= op_e'(cmd_op);
        rs1_q <= cmd_rs1;
        rs2_q <= cmd_rs2;
        rd_q  <= cmd_rd;
      end
      if (state == S_LATCH) begin
        a_q <= rd1;
        b_q <= rd2;
      end
      if (state == S_EXEC && exec_fin) begin
        err   <= exec_err;
        wb_we <= !exec_err;
        if (!exec_err) begin
          result     <= res_nx;
          flag_carry <= carry_nx;
          flag_zero  <= (res_nx == '0);
        end
      end
    end
  end

  always_comb begin
    ra1  = '0;
    ra2  = '0;
    if (state == S_READ || state == S_LATCH) begin
      ra1 = rs1_q;
      ra2 = rs2_q;
    end
    done = (state == S_WB);
    we3  = done && wb_we;
    wa3  = we3 ? rd_q : '0;
    wd3  = we3 ? result : '0;
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit with a behavioural 8x8 register file
// and an arithmetic reference model.
module tb_alu_exec_unit;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_rs1, cmd_rs2, cmd_rd;
  logic [2:0] ra1, ra2, wa3;
  logic [7:0] rd1, rd2, wd3, result;
  logic       we3, done, flag_zero, flag_carry, err;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_rd     (cmd_rd),
    .ra1        (ra1),
    .ra2        (ra2),
    .rd1        (rd1),
    .rd2        (rd2),
    .wa3        (wa3),
    .we3        (we3),
    .wd3        (wd3),
    .done       (done),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .err        (err)
  );

  logic [7:0] rf [8];
  logic [7:0] pl_vals [8];
  logic       pl_all;
  int         we_cnt = 0;

  always @(posedge clk) begin
    if (pl_all) begin
      for (int i = 0; i < 8; i++) rf[i] <= pl_vals[i];
    end else if (we3) begin
      rf[wa3] <= wd3;
    end
    if (we3) we_cnt++;
  end

  assign rd1 = rf[ra1];
  assign rd2 = rf[ra2];

  int nvec = 0;
  int nmis = 0;
  int last_res = 0, last_z = 0, last_c = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void model(input int op, input int a, input int b,
                                output int res, output int c, output int e);
    int p, sa, sb, sh;
    res = 0; c = 0; e = 0;
    case (op)
      0: begin p = a + b; res = p % 256; c = int'(p > 255); end
      1: begin res = (a - b + 256) % 256; c = int'(a < b); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        res = int'(sa < sb);
      end
      6: begin
        sh = b % 8;
        p = a * (1 << sh);
        res = p % 256;
        c = (sh == 0) ? 0 : (p / 256) % 2;
      end
      default: begin
        if (MUL_EN) begin
          p = a * b; res = p % 256; c = int'(p > 255);
        end else begin
          e = 1;
        end
      end
    endcase
  endfunction

  task automatic commit_rf();
    @(negedge clk);
    pl_all = 1'b1;
    @(negedge clk);
    pl_all = 1'b0;
  endtask

  task automatic run_cmd(input int op, input int s1, input int s2, input int d,
                         output int lat, output int nwe, output int ra_a,
                         output int ra_b, output int wa, output int wd,
                         output int res, output int z, output int c,
                         output int e);
    lat = 0; nwe = 0; ra_a = -1; ra_b = -1;
    wa = 0; wd = 0; res = 0; z = 0; c = 0; e = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'(op); cmd_rs1 = 3'(s1); cmd_rs2 = 3'(s2); cmd_rd = 3'(d);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 1) begin ra_a = ra1; ra_b = ra2; end
      if (we3) nwe++;
      if (done) begin
        lat = k; wa = wa3; wd = wd3; res = result;
        z = flag_zero; c = flag_carry; e = err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_cmd(input string nm, input int op, input int s1,
                           input int s2, input int d,
                           output int got_wd, output int got_c);
    int a, b, er, ec, ee, old;
    int lat, nwe, ra_a, ra_b, wa, wd, res, z, c, e;
    a = rf[s1]; b = rf[s2]; old = rf[d];
    model(op, a, b, er, ec, ee);
    run_cmd(op, s1, s2, d, lat, nwe, ra_a, ra_b, wa, wd, res, z, c, e);
    chk({nm, ".latency"}, lat, (op == 7 && MUL_EN) ? 11 : 4);
    chk({nm, ".ra1"}, ra_a, s1);
    chk({nm, ".ra2"}, ra_b, s2);
    chk({nm, ".we3_pulses"}, nwe, ee ? 0 : 1);
    chk({nm, ".wa3"}, wa, ee ? 0 : d);
    chk({nm, ".wd3"}, wd, ee ? 0 : er);
    chk({nm, ".result"}, res, ee ? last_res : er);
    chk({nm, ".zero"}, z, ee ? last_z : int'(er == 0));
    chk({nm, ".carry"}, c, ee ? last_c : ec);
    chk({nm, ".err"}, e, ee);
    @(negedge clk);
    chk({nm, ".ready_after"}, cmd_ready, 1);
    chk({nm, ".rf_rd"}, rf[d], ee ? old : er);
    if (!ee) begin
      last_res = er; last_z = int'(er == 0); last_c = ec;
    end
    got_wd = wd; got_c = c;
  endtask

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int gw, gc, old6, wbase, op;
    int ea, ec, ee, eb, fb, e7;

    tbl[0]  = '{3'd0, 8'h7F, 8'h01, 8'h80, 1'b0};
    tbl[1]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[2]  = '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b1};
    tbl[3]  = '{3'd1, 8'h05, 8'h03, 8'h02, 1'b0};
    tbl[4]  = '{3'd5, 8'hFF, 8'h01, 8'h01, 1'b0};
    tbl[5]  = '{3'd5, 8'h01, 8'hFF, 8'h00, 1'b0};
    tbl[6]  = '{3'd6, 8'h81, 8'h01, 8'h02, 1'b1};
    tbl[7]  = '{3'd6, 8'h81, 8'h00, 8'h81, 1'b0};
    tbl[8]  = '{3'd2, 8'hF0, 8'h3C, 8'h30, 1'b0};
    tbl[9]  = '{3'd3, 8'hF0, 8'h0F, 8'hFF, 1'b0};
    tbl[10] = '{3'd4, 8'hAA, 8'hAA, 8'h00, 1'b0};

    rst = 1'b0; cmd_valid = 1'b0; pl_all = 1'b0;
    cmd_op = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_rd = '0;
    for (int i = 0; i < 8; i++) pl_vals[i] = 8'(i * 17);
    repeat (2) @(negedge clk);
    chk("reset.ready", cmd_ready, 1);
    chk("reset.done", done, 0);
    chk("reset.we3", we3, 0);
    chk("reset.result", result, 0);
    chk("reset.flags", {flag_zero, flag_carry, err}, 0);
    chk("reset.addr", {ra1, ra2, wa3}, 0);
    chk("reset.wd3", wd3, 0);
    rst = 1'b1;
    commit_rf();

    for (int i = 0; i < 11; i++) begin
      pl_vals[1] = tbl[i].a;
      pl_vals[2] = tbl[i].b;
      pl_vals[3] = 8'h5A;
      commit_rf();
      check_cmd($sformatf("tbl%0d", i), int'(tbl[i].op), 1, 2, 3, gw, gc);
      chk($sformatf("tbl%0d.const_wd3", i), gw, int'(tbl[i].res));
      chk($sformatf("tbl%0d.const_carry", i), gc, int'(tbl[i].c));
    end

    pl_vals[1] = 8'h81; pl_vals[2] = 8'h01;
    commit_rf();
    check_cmd("shl_rd_eq_rs1", 6, 1, 2, 1, gw, gc);
    chk("shl_rd_eq_rs1.r1", rf[1], 8'h02);

    pl_vals[1] = 8'h10; pl_vals[2] = 8'h11; pl_vals[3] = 8'h33;
    commit_rf();
    check_cmd("mul", 7, 1, 2, 3, gw, gc);
    chk("mul.const_wd3", gw, MUL_EN ? 8'h10 : 0);

    // two back-to-back commands with valid held high
    for (int i = 0; i < 8; i++) pl_vals[i] = 8'(8'h21 + i * 29);
    commit_rf();
    e7 = rf[7];
    model(0, rf[1], rf[2], ea, ec, ee);
    model(1, rf[1], rf[2], eb, ec, ee);
    wbase = we_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd0; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_rd = 3'd4;
    chk("hs.ready0", cmd_ready, 1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("hs.ready_c%0d", k), cmd_ready, int'(k == 5 || k == 10));
      chk($sformatf("hs.done_c%0d", k), done, int'(k == 4 || k == 9));
      if (k == 1) begin
        cmd_op = 3'd4; cmd_rs1 = 3'd5; cmd_rs2 = 3'd6; cmd_rd = 3'd7;
      end
      if (k == 3) begin
        cmd_op = 3'd1; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_rd = 3'd5;
      end
      if (k == 6) cmd_valid = 1'b0;
    end
    chk("hs.we_count", we_cnt - wbase, 2);
    chk("hs.rf4", rf[4], ea);
    chk("hs.rf5", rf[5], eb);
    chk("hs.rf7_untouched", rf[7], e7);
    last_res = eb; last_z = int'(eb == 0); last_c = int'(rf[1] < rf[2]);

    // reset while the command sits in EXEC
    pl_vals[6] = 8'hC3;
    commit_rf();
    old6 = rf[6];
    wbase = we_cnt;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 3'd0; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2; cmd_rd = 3'd6;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_exec.ready", cmd_ready, 1);
    chk("rst_exec.done_we", {done, we3}, 0);
    chk("rst_exec.result", result, 0);
    chk("rst_exec.flags", {flag_zero, flag_carry, err}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_exec.no_we", we_cnt - wbase, 0);
    chk("rst_exec.rf6", rf[6], old6);
    last_res = 0; last_z = 0; last_c = 0;
    check_cmd("after_rst", 0, 1, 2, 6, gw, gc);

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 8; i++) pl_vals[i] = 8'($urandom_range(0, 255));
      if (n % 5 == 0) pl_vals[2] = 8'($urandom_range(0, 7));
      commit_rf();
      op = $urandom_range(0, 7);
      check_cmd($sformatf("rnd%0d", n), op, $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), gw, gc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute and write-back stage directly downstream of the `RegisterFile`. It accepts one ALU command at a time through a valid/ready handshake and drives the file's read addresses (`ra1`/`ra2`). It captures both operands, computes the result, then drives the file's write port (`wa3`/`we3`/`wd3`) for one cycle. On the board top it replaces the switch-driven register-file control, with the result routed to the 7-segment decoders.

## Interface
- `DATA_W`, 8: operand/result width; equals register-file data width
- `ADDR_W`, 3: register address width (8 registers)
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command; high only in IDLE
- `cmd_op`  in  3  operation code, see Operation
- `cmd_rs1`, `cmd_rs2`, `cmd_rd`  in  ADDR_W each  source A, source B, destination
- `ra1`, `ra2`  out  ADDR_W  register-file read addresses
- `rd1`, `rd2`  in  DATA_W  register-file read data (`saida_rd1`/`saida_rd2`)
- `wa3`  out  ADDR_W  write address
- `we3`  out  1  write enable, single-cycle pulse
- `wd3`  out  DATA_W  write data
- `done`  out  1  one-cycle pulse, coincident with write-back or error
- `result`  out  DATA_W  last computed result, held until next `done`
- `flag_zero`, `flag_carry`, `err`  out  1 each  status of last command, held until next `done`

## Operation
- The command is accepted on an edge with `cmd_valid & cmd_ready`. The op, rs1, rs2 and rd are latched. `cmd_valid` while busy is ignored, never queued.
- FSM states, with transitions taken unconditionally unless noted:
  - IDLE → READ on accept.
  - READ: `ra1`/`ra2` driven from latched rs1/rs2. → LATCH.
  - LATCH: addresses still held; `rd1`/`rd2` captured into operand registers at end of cycle. This works with combinational or 1-cycle-registered read ports. → EXEC.
  - EXEC: compute. → WB, or stays for MUL iterations.
  - WB: `we3`=1, `wa3`=rd, `wd3`=result, `done`=1, status outputs update. → IDLE.
- Ops (`cmd_op`):
  - 000 ADD: carry = bit DATA_W of the (DATA_W+1)-bit sum.
  - 001 SUB: A−B; carry = borrow, i.e. 1 iff A<B unsigned.
  - 010 AND, 011 OR, 100 XOR: carry 0.
  - 101 SLT: signed A<B gives 1, else 0; carry 0.
  - 110 SHL: A << B[2:0]; carry = last bit shifted out, 0 if shift is 0.
  - 111 MUL: low DATA_W bits of A×B; carry = 1 iff upper product bits are nonzero.
- `flag_zero` = (result == 0).
- rd may equal rs1 or rs2. Operands are already latched, so the new value is written with no hazard.
- `ra1`/`ra2` are 0 outside READ/LATCH. `wa3`/`wd3` are 0 when `we3`=0.

## Timing
- Reset (async, any state): FSM → IDLE.
  - `cmd_ready`=1.
  - `we3`, `done`, `err`, `flag_zero`, `flag_carry` = 0.
  - `result`, `ra1`, `ra2`, `wa3`, `wd3` = 0.
  - Operand registers cleared.
- Reset during READ..WB aborts the command: no `we3` pulse, no `done`.
- Non-MUL latency: accept at edge 0 → READ cycle 1, LATCH 2, EXEC 3, WB 4 (`we3`/`done` high). `cmd_ready` is high again in cycle 5. Throughput is one command per 5 cycles.
- MUL: EXEC lasts DATA_W cycles (shift-add, one bit per cycle). WB occurs in cycle 3+DATA_W (cycle 11 for DATA_W=8).
- `cmd_ready` is low in every state except IDLE. A new command can be accepted on the first IDLE edge after WB.

## Configuration
- `ALU_MUL_EN` defined: op 111 is executed as MUL with the iterative sub-module.
- `ALU_MUL_EN` undefined: the multiplier is not instantiated. Op 111 is illegal:
  - EXEC → WB in one cycle with `we3`=0.
  - `done`=1, `err`=1.
  - `result`, `flag_zero` and `flag_carry` keep their previous values.
  - The register file is unchanged.
- `err` is 0 for every legal op in both builds.

## Structure
- Package `alu_pkg`: op-code enum (`OP_ADD`…`OP_MUL`), FSM state enum, `DATA_W`/`ADDR_W` default constants.
- Sub-module `seq_multiplier`:
  - Interface: start, A, B in; busy, done, product (2·DATA_W) out.
  - Instantiated only under `ALU_MUL_EN`.
- Everything else is in `alu_exec_unit`.

## Test plan
All scenarios use a behavioural 8×8 register file with preloaded values.
- ADD: R1=0x7F, R2=0x01, rd=R3 → `we3` in cycle 4, `wa3`=3, `wd3`=0x80, zero=0, carry=0; R3 reads 0x80 afterwards.
- ADD wrap: R1=0xFF, R2=0x01 → `wd3`=0x00, zero=1, carry=1. SUB 0x03−0x05 → 0xFE, carry=1.
- SLT: R1=0xFF (−1), R2=0x01 → `wd3`=0x01. SHL: R1=0x81, shift 1 → 0x02, carry=1. rd=rs1 case: R1 gets the new value.
- MUL (`ALU_MUL_EN`): 0x10×0x11 → `wd3`=0x10, carry=1, `done` in cycle 11. Without the macro: `done`=1, `err`=1, no `we3`.
- Handshake: hold `cmd_valid`=1 continuously with two commands → second accepted only in cycle 5; a command changed while busy is ignored.
- Reset: assert `rst`=0 during EXEC → outputs at reset values immediately, no `we3` ever seen for that command; next command completes normally.
